// File: rtl/mod_cmd_decoder_if.sv
// Host byte link plus modulation-stage control outputs of the command decoder.
// The slave modport is the decoder side; master is the host/modulator side.
interface mod_cmd_decoder_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] mod_half_period;
    logic        mod_set;
    logic        mod_enable;
    logic        cmd_err;
    logic        busy;

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mod_half_period, mod_set, mod_enable, cmd_err, busy
    );

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mod_half_period, mod_set, mod_enable, cmd_err, busy
    );
endinterface

// File: rtl/mod_cmd_decoder.sv
// Byte-stream command decoder: SET_PERIOD / SET_ENABLE / DISABLE packets
// drive the modulation stage; stalled packets are aborted after a timeout.
module mod_cmd_decoder #(
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    mod_cmd_decoder_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PERIOD_HI  = 3'd1,
        PERIOD_LO  = 3'd2,
        ENABLE_ARG = 3'd3,
        ISSUE      = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] tmo_cnt, tmo_cnt_nxt;
    logic [7:0]    hi_byte, hi_byte_nxt;
    logic [15:0]   half_period, half_period_nxt;
    logic          enable, enable_nxt;
    logic          err_strobe, err_strobe_nxt;
    logic          set_strobe, set_strobe_nxt;
    logic          busy_flag, busy_flag_nxt;
    logic          ready, ready_nxt;
    logic          accept;
    logic          expire;
    logic          bad_opcode;

    function automatic logic is_waiting(input state_t s);
        return (s == PERIOD_HI) || (s == PERIOD_LO) || (s == ENABLE_ARG);
    endfunction

    assign accept     = bus.rx_valid && ready;
    // An accepted byte on the expiry edge wins, so expiry requires no accept.
    assign expire     = is_waiting(state) && !accept && (tmo_cnt >= TMO_LAST);
    assign bad_opcode = (state == IDLE) && accept &&
                        (bus.rx_data != 8'hA0) && (bus.rx_data != 8'hA1) &&
                        (bus.rx_data != 8'hA2);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (bus.rx_data)
                        8'hA0:   state_nxt = PERIOD_HI;
                        8'hA1:   state_nxt = ENABLE_ARG;
                        default: state_nxt = IDLE;
                    endcase
                end else begin
                    state_nxt = IDLE;
                end
            end
            PERIOD_HI: begin
                if (accept)      state_nxt = PERIOD_LO;
                else if (expire) state_nxt = IDLE;
                else             state_nxt = PERIOD_HI;
            end
            PERIOD_LO: begin
                if (accept)      state_nxt = ISSUE;
                else if (expire) state_nxt = IDLE;
                else             state_nxt = PERIOD_LO;
            end
            ENABLE_ARG: begin
                if (accept || expire) state_nxt = IDLE;
                else                  state_nxt = ENABLE_ARG;
            end
            ISSUE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output and datapath next values, registered below.
    always_comb begin
        hi_byte_nxt     = hi_byte;
        half_period_nxt = half_period;
        enable_nxt      = enable;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (bus.rx_data == 8'hA2) enable_nxt = 1'b0;
                    else                      enable_nxt = enable;
                end
                PERIOD_HI:  hi_byte_nxt     = bus.rx_data;
                PERIOD_LO:  half_period_nxt = {hi_byte, bus.rx_data};
                ENABLE_ARG: enable_nxt      = bus.rx_data[0];
                default:    hi_byte_nxt     = hi_byte;
            endcase
        end else begin
            hi_byte_nxt = hi_byte;
        end

        if (!is_waiting(state_nxt) || accept || (state_nxt != state)) begin
            tmo_cnt_nxt = {CW{1'b0}};
        end else if (tmo_cnt == TMO_MAX) begin
            tmo_cnt_nxt = tmo_cnt;
        end else begin
            tmo_cnt_nxt = tmo_cnt + CW'(1);
        end

        err_strobe_nxt = bad_opcode || expire;
        set_strobe_nxt = (state_nxt == ISSUE);
        busy_flag_nxt  = (state_nxt != IDLE);
        ready_nxt      = (state_nxt != ISSUE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt     <= {CW{1'b0}};
            hi_byte     <= 8'h00;
            half_period <= 16'h0000;
            enable      <= 1'b0;
            err_strobe  <= 1'b0;
            set_strobe  <= 1'b0;
            busy_flag   <= 1'b0;
            ready       <= 1'b0;
        end else begin
            tmo_cnt     <= tmo_cnt_nxt;
            hi_byte     <= hi_byte_nxt;
            half_period <= half_period_nxt;
            enable      <= enable_nxt;
            err_strobe  <= err_strobe_nxt;
            set_strobe  <= set_strobe_nxt;
            busy_flag   <= busy_flag_nxt;
            ready       <= ready_nxt;
        end
    end

    assign bus.rx_ready        = ready;
    assign bus.mod_half_period = half_period;
    assign bus.mod_set         = set_strobe;
    assign bus.mod_enable      = enable;
    assign bus.cmd_err         = err_strobe;
    assign bus.busy            = busy_flag;
endmodule

// File: doc/mod_cmd_decoder.md
MOD_CMD_DECODER -- requirements
Module: mod_cmd_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 500000: idle cycles allowed between bytes of one packet before the packet is aborted.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port rx_data  input  8  command byte from the host link.
REQ-005 SHALL have port rx_valid  input  1  rx_data is valid.
REQ-006 SHALL have port rx_ready  output  1  decoder can accept a byte; a byte transfers on a rising edge where rx_valid and rx_ready are both 1.
REQ-007 SHALL have port mod_half_period  output  16  modulation half-period for the modulation stage, in sync ticks.
REQ-008 SHALL have port mod_set  output  1  one-cycle strobe: mod_half_period holds a new value.
REQ-009 SHALL have port mod_enable  output  1  level enable to the modulation stage.
REQ-010 SHALL have port cmd_err  output  1  one-cycle strobe: bad opcode or packet timeout.
REQ-011 SHALL have port busy  output  1  high while in any state other than IDLE.

Function
REQ-012 SHALL decode these opcodes, taken from the first byte of a packet:
- 0xA0 SET_PERIOD: followed by 2 bytes, high byte first.
- 0xA1 SET_ENABLE: followed by 1 byte; bit0 is the new mod_enable and bits 7:1 are ignored.
- 0xA2 DISABLE: no argument bytes.
REQ-013 SHALL implement exactly these states: IDLE, PERIOD_HI, PERIOD_LO, ENABLE_ARG, ISSUE.
REQ-014 SHALL make these transitions from IDLE on an accepted byte:
- 0xA0 -> PERIOD_HI.
- 0xA1 -> ENABLE_ARG.
- 0xA2 -> stay in IDLE; mod_enable becomes 0 on the same edge.
- Any other value -> stay in IDLE; cmd_err is 1 for the next cycle.
REQ-015 SHALL, in PERIOD_HI, store the accepted byte in an internal high-byte register and go to PERIOD_LO.
REQ-016 SHALL, in PERIOD_LO on an accepted byte, load mod_half_period with {high byte, accepted byte} on that edge and go to ISSUE.
REQ-017 SHALL assert mod_set for exactly the one cycle spent in ISSUE, then return to IDLE; mod_set latency is 1 cycle after the low-byte handshake edge.
REQ-018 SHALL hold rx_ready at 0 in ISSUE and at 1 in every other state, except during reset.
REQ-019 SHALL, in ENABLE_ARG on an accepted byte, load mod_enable with rx_data[0] on that edge, go to IDLE, and not pulse mod_set.
REQ-020 SHALL hold mod_half_period unchanged except at the PERIOD_LO load.
REQ-021 SHALL hold mod_enable unchanged except at the DISABLE and SET_ENABLE updates.
REQ-022 SHALL accept a period value of 0x0000 and issue it like any other value.
REQ-023 SHALL run a timeout counter only in PERIOD_HI, PERIOD_LO and ENABLE_ARG.
- Cleared on every accepted byte and on entry to any of those states.
- Saturates; does not wrap.
REQ-024 SHALL handle counter expiry (counter reaches TIMEOUT_CYCLES with no accepted byte) as follows:
- Go to IDLE.
- Pulse cmd_err for 1 cycle.
- Discard partial data; mod_half_period, mod_enable and mod_set are unaffected.
REQ-025 SHALL give the byte priority when a byte is accepted on the same edge the counter would expire; no cmd_err occurs.
REQ-026 SHALL keep cmd_err and mod_set mutually exclusive; each is high for at most one consecutive cycle per event.
REQ-027 SHALL accept a new opcode on the cycle immediately after ISSUE.

Reset
REQ-028 SHALL, while rst is high, immediately force the following regardless of clk:
- State IDLE, timeout counter 0, high-byte register 0.
- mod_half_period 0x0000.
- mod_set 0, mod_enable 0, cmd_err 0, busy 0, rx_ready 0.
REQ-029 SHALL discard any partial packet when reset is asserted mid-packet, and produce no strobe on release.
REQ-030 SHALL drive rx_ready to 1 on the first rising edge after rst is released.

Verification
REQ-031 SHALL cover: bytes A0,12,34 back-to-back -> mod_half_period=0x1234 and mod_set=1 for exactly one cycle, one cycle after the 0x34 handshake; rx_ready=0 in that cycle.
REQ-032 SHALL cover: A1,03 then A2 -> mod_enable goes 1 after 0x03, then 0 after 0xA2; mod_set never asserted.
REQ-033 SHALL cover: byte 0x55 in IDLE -> cmd_err one-cycle pulse; all outputs otherwise unchanged.
REQ-034 SHALL cover, with TIMEOUT_CYCLES=8: A0,12 followed by a 10-cycle gap -> cmd_err pulse, return to IDLE, mod_half_period still at its prior value; a following A0,00,05 -> mod_half_period=0x0005 with mod_set.
REQ-035 SHALL cover: A0,12 then rst pulsed mid-packet -> all outputs at reset values, no strobes; a following A0,AB,CD -> mod_half_period=0xABCD.
REQ-036 SHALL cover, with TIMEOUT_CYCLES=8: a byte accepted exactly on the expiry edge -> packet continues and no cmd_err.
